// File: rtl/mem_c_collect_if.sv
// Purpose : bundle of handshake/data signals between a systolic array tile
//           collector (slave) and whoever feeds it and reads it back (master).
// Ports   : start/Cin/rd_en/Crow into the collector; busy/done/Cout/rd_valid out.
interface mem_c_collect_if #(
  parameter int BITS_C = 16,
  parameter int DIM    = 8
);
  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;

  logic                     start;
  logic signed [BITS_C-1:0] Cin [DIM];
  logic                     busy;
  logic                     done;
  logic                     rd_en;
  logic [CW-1:0]            Crow;
  logic signed [BITS_C-1:0] Cout [DIM];
  logic                     rd_valid;

  modport master (
    output start, Cin, rd_en, Crow,
    input  busy, done, Cout, rd_valid
  );

  modport slave (
    input  start, Cin, rd_en, Crow,
    output busy, done, Cout, rd_valid
  );
endinterface

// File: rtl/mem_c_collect.sv
// Purpose : captures the skewed column outputs of a DIM x DIM systolic array
//           into a de-skewed tile, then serves it back one row per read.
// Latency : capture window 2*DIM-1 cycles after the start edge; row reads 1 cycle.
// Flow    : no backpressure; start is ignored mid-capture, reads are accepted
//           every cycle in READY only, and start wins over a same-cycle read.
// Ports   : clk, rst (async, active-high); bus = mem_c_collect_if.slave
//           (start, Cin[DIM], busy, done, rd_en, Crow, Cout[DIM], rd_valid).
// Config  : MEMC_ACCUM_EN defined -> captured values are saturating-added to
//           the held tile (tiled accumulation); undefined -> plain overwrite.
module mem_c_collect #(
  parameter int BITS_C = 16,
  parameter int DIM    = 8
) (
  input logic           clk,
  input logic           rst,
  mem_c_collect_if.slave bus
);
  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int KW = (DIM > 1) ? $clog2(2*DIM-1) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(2*DIM-2);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_READY   = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [KW-1:0]            r_k;
  logic signed [BITS_C-1:0] r_mem  [DIM][DIM];   // [row][col]
  logic signed [BITS_C-1:0] r_cout [DIM];
  logic                     r_rd_valid;

  logic                     w_lane_en  [DIM];
  logic [CW-1:0]            w_lane_row [DIM];
  logic signed [BITS_C-1:0] w_wr       [DIM];
  logic                     w_rd_accept;

`ifdef MEMC_ACCUM_EN
  localparam logic signed [BITS_C-1:0] SAT_MAX = {1'b0, {(BITS_C-1){1'b1}}};
  localparam logic signed [BITS_C-1:0] SAT_MIN = {1'b1, {(BITS_C-1){1'b0}}};
  logic signed [BITS_C:0]   w_sum [DIM];
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (bus.start)      w_state_nxt = S_CAPTURE;
      S_CAPTURE: if (r_k == K_LAST)  w_state_nxt = S_READY;
      S_READY:   if (bus.start)      w_state_nxt = S_CAPTURE;
      default:                       w_state_nxt = S_IDLE;
    endcase
  end

  // Start takes precedence over a read issued in the same READY cycle.
  assign w_rd_accept = (r_state == S_READY) && bus.rd_en && !bus.start;

  // ---------------- lane de-skew ----------------
  // Column j lags column 0 by j cycles, so at counter k lane j carries row k-j.
  always_comb begin
    for (int j = 0; j < DIM; j++) begin
      w_lane_en[j]  = 1'b0;
      w_lane_row[j] = '0;
      w_wr[j]       = bus.Cin[j];
      if (r_state == S_CAPTURE && int'(r_k) >= j && int'(r_k) - j < DIM) begin
        w_lane_en[j]  = 1'b1;
        w_lane_row[j] = CW'(int'(r_k) - j);
      end
`ifdef MEMC_ACCUM_EN
      // One extra bit catches overflow; differing top bits mean saturate.
      w_sum[j] = {r_mem[w_lane_row[j]][j][BITS_C-1], r_mem[w_lane_row[j]][j]}
               + {bus.Cin[j][BITS_C-1], bus.Cin[j]};
      if (w_sum[j][BITS_C] != w_sum[j][BITS_C-1])
        w_wr[j] = w_sum[j][BITS_C] ? SAT_MIN : SAT_MAX;
      else
        w_wr[j] = w_sum[j][BITS_C-1:0];
`endif
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k        <= '0;
      r_rd_valid <= 1'b0;
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
          r_mem[r][c] <= '0;
      for (int j = 0; j < DIM; j++)
        r_cout[j] <= '0;
    end else begin
      // Counter sits at 0 outside CAPTURE, so a new window always starts at k=0.
      if (r_state == S_CAPTURE)
        r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
      else
        r_k <= '0;

      for (int j = 0; j < DIM; j++)
        if (w_lane_en[j])
          r_mem[w_lane_row[j]][j] <= w_wr[j];

      r_rd_valid <= w_rd_accept;
      if (w_rd_accept) begin
        for (int j = 0; j < DIM; j++)
          r_cout[j] <= (int'(bus.Crow) < DIM) ? r_mem[bus.Crow][j] : '0;
      end
    end
  end

  assign bus.busy     = (r_state == S_CAPTURE);
  assign bus.done     = (r_state == S_READY);
  assign bus.rd_valid = r_rd_valid;
  assign bus.Cout     = r_cout;

endmodule

// File: doc/mem_c_collect.md
MEM_C_COLLECT -- requirements
Module: mem_c_collect

Interface
REQ-001 SHALL have parameter BITS_C, default 16: signed width of each result element.
REQ-002 SHALL have parameter DIM, default 8: systolic array dimension (DIM x DIM result tile).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a capture window.
REQ-006 SHALL have port Cin  input  DIM x BITS_C signed  skewed column outputs of the array; Cin[j] is column j.
REQ-007 SHALL have port busy  output  1  high while capturing.
REQ-008 SHALL have port done  output  1  high while a complete tile is held and readable.
REQ-009 SHALL have port rd_en  input  1  row read request.
REQ-010 SHALL have port Crow  input  $clog2(DIM)  row index to read.
REQ-011 SHALL have port Cout  output  DIM x BITS_C signed  de-skewed row; Cout[j] is column j.
REQ-012 SHALL have port rd_valid  output  1  Cout holds valid data this cycle.

Function
REQ-013 SHALL implement the states IDLE, CAPTURE and READY.
REQ-014 SHALL leave IDLE for CAPTURE on start, clear the cycle counter k to 0, and raise busy on the next edge.
REQ-015 SHALL, in CAPTURE at counter value k, store Cin[j] into C[k-j][j] for every j with 0 <= k-j < DIM, and ignore all other lanes.
REQ-016 SHALL take the counter k from 0 to 2*DIM-2, so the window lasts exactly 2*DIM-1 cycles.
REQ-017 SHALL, after the k=2*DIM-2 capture edge, enter READY, drop busy and raise done on that same edge.
REQ-018 SHALL ignore start while in CAPTURE; the window runs to completion.
REQ-019 SHALL, on start in READY, clear done and re-enter CAPTURE; held data is overwritten lane by lane as it arrives.
REQ-020 SHALL, on rd_en in READY, drive Cout = C[Crow] and rd_valid=1 one cycle later (1-cycle latency); back-to-back reads are allowed every cycle.
REQ-021 SHALL, on rd_en in IDLE or CAPTURE, ignore the request: rd_valid=0 and Cout holds its previous value.
REQ-022 SHALL give start priority over rd_en when both are asserted in the same cycle in READY: no read and rd_valid=0.
REQ-023 SHALL return all-zero data with rd_valid=1 when Crow >= DIM (possible only for non-power-of-2 DIM).
REQ-024 SHALL hold rd_valid low in any cycle with no accepted read.

Reset
REQ-025 SHALL, on rst, immediately force state to IDLE, k=0, busy=0, done=0, rd_valid=0, all Cout lanes to 0 and all C storage to 0.
REQ-026 SHALL, on rst during CAPTURE, discard the partial tile and zero the storage; the first start after deassertion begins a fresh window.

Configuration
REQ-027 SHALL use the macro MEMC_ACCUM_EN to select how captured values are written to storage.
REQ-028 SHALL, with MEMC_ACCUM_EN defined, write C[k-j][j] <= sat(C[k-j][j] + Cin[j]), saturating to [-2^(BITS_C-1), 2^(BITS_C-1)-1] for tiled accumulation; storage is zeroed only by rst.
REQ-029 SHALL, without MEMC_ACCUM_EN, overwrite C[k-j][j] <= Cin[j].

Verification
REQ-030 SHALL cover: DIM=8; start, then drive Cin[j] = 16*(k-j)+j for lanes in range over 15 cycles -> done rises after exactly 15 capture edges; reading Crow=3 gives Cout[j]=48+j one cycle after rd_en.
REQ-031 SHALL cover: read rows 0..7 back-to-back in READY -> rd_valid high for 8 consecutive cycles with rows in order.
REQ-032 SHALL cover: start pulsed again at k=5 mid-capture -> ignored; done still rises after 15 cycles total.
REQ-033 SHALL cover: rst asserted at k=7 -> busy=0 and done=0 immediately; a subsequent full read after a new capture with Cin=0 returns all zeros.
REQ-034 SHALL cover: rd_en and start together in READY -> rd_valid=0 next cycle and busy=1.
REQ-035 SHALL cover, with MEMC_ACCUM_EN defined: two captures of 16'sd20000 at element [0][0] -> reads 32767; without the macro -> reads 20000.
